// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, SB, SH, SW} lsu_op_t;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} lsu_size_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} lsu_state_t;

  function automatic logic lsu_is_store(input lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic lsu_size_t lsu_size(input lsu_op_t op);
    lsu_size_t s;
    case (op)
      LB, LBU, SB: s = SZ_BYTE;
      LH, LHU, SH: s = SZ_HALF;
      default:     s = SZ_WORD;
    endcase
    return s;
  endfunction

  function automatic logic lsu_misaligned(input lsu_op_t op, input logic [1:0] off);
    logic m;
    case (lsu_size(op))
      SZ_HALF: m = off[0];
      SZ_WORD: m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / data replication and load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t     st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  lsu_op_t     ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    st_be        = 4'b1111;
    st_wdata_rep = st_wdata;
    case (lsu_size(st_op))
      SZ_BYTE: begin
        st_be        = 4'b0001 << st_off;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be        = 4'b0011 << st_off;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be        = 4'b1111;
        st_wdata_rep = st_wdata;
      end
    endcase
  end

  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    ld_data = '0;
    case (ld_op)
      LB:      ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     ld_data = {24'h0, shifted[7:0]};
      LH:      ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     ld_data = {16'h0, shifted[15:0]};
      LW:      ld_data = ld_rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding req/gnt + rvalid bus access, registered outputs.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  lsu_op_t     op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  lsu_state_t  state, state_next;
  lsu_op_t     op_q;
  logic [1:0]  off_q;
  logic [CW-1:0] cnt;

  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic [31:0] ld_data;

  logic timeout_hit;
  logic launch;
  logic req_drop;
  logic rsp_set;
  logic rsp_err_set;
  logic rsp_load;

  lsu_align u_align (
    .st_op        (op),
    .st_off       (addr[1:0]),
    .st_wdata     (wdata),
    .st_be        (be_in),
    .st_wdata_rep (wdata_in),
    .ld_op        (op_q),
    .ld_off       (off_q),
    .ld_rdata     (mem_rdata),
    .ld_data      (ld_data)
  );

  // cnt holds the number of REQ/RESP cycles already elapsed, so a hit here
  // means this cycle is the BUS_TIMEOUT-th one.
  assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt == CW'(BUS_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    req_drop    = 1'b0;
    rsp_set     = 1'b0;
    rsp_err_set = 1'b0;
    rsp_load    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (lsu_misaligned(op, addr[1:0])) begin
            state_next = ERR;
          end else begin
            state_next = REQ;
            launch     = 1'b1;
          end
        end
      end
      REQ: begin
        if (timeout_hit) begin
          state_next  = IDLE;
          req_drop    = 1'b1;
          rsp_set     = 1'b1;
          rsp_err_set = 1'b1;
        end else if (mem_gnt) begin
          state_next = RESP;
          req_drop   = 1'b1;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_next  = IDLE;
          rsp_set     = 1'b1;
          rsp_err_set = mem_err;
          rsp_load    = !mem_err;
        end else if (timeout_hit) begin
          state_next  = IDLE;
          rsp_set     = 1'b1;
          rsp_err_set = 1'b1;
        end
      end
      ERR: begin
        state_next  = IDLE;
        rsp_set     = 1'b1;
        rsp_err_set = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      op_q      <= LB;
      off_q     <= '0;
      cnt       <= '0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= rsp_set;
      rsp_err   <= rsp_err_set;
      rsp_rdata <= rsp_load ? ld_data : '0;
      if (launch) begin
        mem_req   <= 1'b1;
        mem_we    <= lsu_is_store(op);
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= be_in;
        mem_wdata <= wdata_in;
        op_q      <= op;
        off_q     <= addr[1:0];
        cnt       <= '0;
      end else begin
        if (req_drop) mem_req <= 1'b0;
        if ((state == REQ) || (state == RESP)) cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: expected responses queued at accept, compared on rsp_valid.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  lsu_op_t     op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  lsu_op_t     ld_ops[6]   = '{LB, LBU, LH, LHU, LB, LBU};
  logic [31:0] ld_addrs[6] = '{32'h2003, 32'h2003, 32'h2002, 32'h2000, 32'h2001, 32'h2002};
  logic [3:0]  ld_bes[6]   = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b0100};
  logic [31:0] ld_exps[6]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012,
                               32'h00003456, 32'h00000034, 32'h00000012};

  lsu_op_t     st_ops[3]   = '{SH, SB, SW};
  logic [31:0] st_addrs[3] = '{32'h3002, 32'h3001, 32'h3004};
  logic [31:0] st_wds[3]   = '{32'hABCD1234, 32'h000000A5, 32'h01234567};
  logic [3:0]  st_bes[3]   = '{4'b1100, 4'b0010, 4'b1111};
  logic [31:0] st_reps[3]  = '{32'h12341234, 32'hA5A5A5A5, 32'h01234567};

  lsu #(.BUS_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  // Presents one request for a single cycle; returns at the negedge after the accepting edge.
  task automatic send(input lsu_op_t o, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    op        = o;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Grants after gnt_wait idle cycles, then returns rvalid on the following cycle.
  task automatic do_bus(input int gnt_wait, input logic [31:0] rd, input logic er);
    repeat (gnt_wait) @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    mem_err    = er;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; op = LB; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if ({rsp_err, rsp_rdata} !== 33'h0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_err, rsp_rdata}); end
    total++; if ({mem_req, mem_we, mem_be} !== 6'h0) begin bad++; $display("FAIL reset_mem_ctl got=%h exp=0", {mem_req, mem_we, mem_be}); end
    total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL reset_mem_data got=%h exp=0", {mem_addr, mem_wdata}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw;
    exp_t e;
    sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0});
    send(LW, 32'h1000, 32'h0);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL lw_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h1000) begin bad++; $display("FAIL lw_addr got=%h exp=00001000", mem_addr); end
    total++; if (mem_be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b exp=1111", mem_be); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL lw_we got=%b exp=0", mem_we); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL lw_ready_busy got=%b exp=0", req_ready); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_req_drop got=%b exp=0", mem_req); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL lw_early_rsp got=%b exp=0", rsp_valid); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    e = sb.pop_front();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL lw_rsp_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL lw_rdata got=%h exp=%h", rsp_rdata, e.rdata); end
    total++; if (rsp_err !== e.err) begin bad++; $display("FAIL lw_err got=%b exp=%b", rsp_err, e.err); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lw_ready_done got=%b exp=1", req_ready); end
    @(negedge clk);
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin bad++; $display("FAIL lw_pulse_end got=%h exp=0", {rsp_valid, rsp_err, rsp_rdata}); end
  endtask

  task automatic test_loads;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{rdata: ld_exps[i], err: 1'b0});
      send(ld_ops[i], ld_addrs[i], 32'hFFFFFFFF);
      total++; if (mem_be !== ld_bes[i]) begin bad++; $display("FAIL load%0d_be got=%b exp=%b", i, mem_be, ld_bes[i]); end
      total++; if (mem_addr !== {ld_addrs[i][31:2], 2'b00}) begin bad++; $display("FAIL load%0d_addr got=%h exp=%h", i, mem_addr, {ld_addrs[i][31:2], 2'b00}); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL load%0d_we got=%b exp=0", i, mem_we); end
      do_bus(0, 32'h80123456, 1'b0);
      e = sb.pop_front();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL load%0d_valid got=%b exp=1", i, rsp_valid); end
      total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rsp_rdata, e.rdata); end
      total++; if (rsp_err !== e.err) begin bad++; $display("FAIL load%0d_err got=%b exp=%b", i, rsp_err, e.err); end
    end
  endtask

  task automatic test_store;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b0});
      send(st_ops[i], st_addrs[i], st_wds[i]);
      total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL store%0d_we got=%b exp=1", i, mem_we); end
      total++; if (mem_be !== st_bes[i]) begin bad++; $display("FAIL store%0d_be got=%b exp=%b", i, mem_be, st_bes[i]); end
      total++; if (mem_wdata !== st_reps[i]) begin bad++; $display("FAIL store%0d_wdata got=%h exp=%h", i, mem_wdata, st_reps[i]); end
      total++; if (mem_addr !== {st_addrs[i][31:2], 2'b00}) begin bad++; $display("FAIL store%0d_addr got=%h exp=%h", i, mem_addr, {st_addrs[i][31:2], 2'b00}); end
      do_bus(0, 32'hFFFFFFFF, 1'b0);
      e = sb.pop_front();
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL store%0d_valid got=%b exp=1", i, rsp_valid); end
      total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL store%0d_rdata got=%h exp=%h", i, rsp_rdata, e.rdata); end
      total++; if (rsp_err !== e.err) begin bad++; $display("FAIL store%0d_err got=%b exp=%b", i, rsp_err, e.err); end
    end
  endtask

  task automatic test_misaligned;
    exp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    send(LW, 32'h1002, 32'h0);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_lw_req got=%b exp=0", mem_req); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mis_lw_early got=%b exp=0", rsp_valid); end
    @(negedge clk);
    e = sb.pop_front();
    total++; if ({rsp_valid, rsp_err} !== {1'b1, e.err}) begin bad++; $display("FAIL mis_lw_rsp got=%b%b exp=1%b", rsp_valid, rsp_err, e.err); end
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL mis_lw_rdata got=%h exp=%h", rsp_rdata, e.rdata); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mis_b2b_ready got=%b exp=1", req_ready); end
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    send(SH, 32'h1001, 32'h0000FFFF);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_sh_req got=%b exp=0", mem_req); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mis_sh_pulse_end got=%b exp=0", rsp_valid); end
    @(negedge clk);
    e = sb.pop_front();
    total++; if ({rsp_valid, rsp_err} !== {1'b1, e.err}) begin bad++; $display("FAIL mis_sh_rsp got=%b%b exp=1%b", rsp_valid, rsp_err, e.err); end
    total++; if ({mem_req, rsp_rdata} !== {1'b0, e.rdata}) begin bad++; $display("FAIL mis_sh_rdata got=%h exp=%h", {mem_req, rsp_rdata}, {1'b0, e.rdata}); end
  endtask

  task automatic test_delayed_gnt;
    exp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b1});
    send(SW, 32'h4004, 32'hCAFEF00D);
    for (int k = 0; k < 4; k++) begin
      total++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 32'h4004, 4'b1111, 32'hCAFEF00D})
        begin bad++; $display("FAIL hold%0d_bus got=%b/%h/%b/%h exp=1/00004004/1111/cafef00d", k, mem_req, mem_addr, mem_be, mem_wdata); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL hold%0d_ready got=%b exp=0", k, req_ready); end
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hold_req_drop got=%b exp=0", mem_req); end
    mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    e = sb.pop_front();
    total++; if ({rsp_valid, rsp_err} !== {1'b1, e.err}) begin bad++; $display("FAIL buserr_rsp got=%b%b exp=1%b", rsp_valid, rsp_err, e.err); end
    total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL buserr_rdata got=%h exp=%h", rsp_rdata, e.rdata); end
  endtask

  task automatic test_timeout;
    exp_t e;
    for (int ph = 0; ph < 2; ph++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1});
      send(LW, 32'h5000, 32'h0);
      // ph 0: never granted; ph 1: granted in cycle 1, never answered
      for (int c = 1; c <= 8; c++) begin
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL to%0d_c%0d_early got=%b exp=0", ph, c, rsp_valid); end
        if (ph == 0) begin
          total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL to%0d_c%0d_req got=%b exp=1", ph, c, mem_req); end
        end
        mem_gnt = (ph == 1) && (c == 1);
        @(negedge clk);
        mem_gnt = 1'b0;
      end
      e = sb.pop_front();
      total++; if ({rsp_valid, rsp_err} !== {1'b1, e.err}) begin bad++; $display("FAIL to%0d_rsp got=%b%b exp=1%b", ph, rsp_valid, rsp_err, e.err); end
      total++; if ({mem_req, req_ready} !== 2'b01) begin bad++; $display("FAIL to%0d_state got=%b%b exp=01", ph, mem_req, req_ready); end
      total++; if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL to%0d_rdata got=%h exp=%h", ph, rsp_rdata, e.rdata); end
    end
  endtask

  task automatic test_stray_inputs;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    total++; if ({rsp_valid, mem_req, req_ready} !== 3'b001) begin bad++; $display("FAIL stray got=%b exp=001", {rsp_valid, mem_req, req_ready}); end
  endtask

  task automatic test_reset_mid;
    send(SW, 32'h6004, 32'h00000055);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({mem_req, mem_we, mem_be} !== 6'h0) begin bad++; $display("FAIL rstmid_ctl got=%h exp=0", {mem_req, mem_we, mem_be}); end
    total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", {mem_addr, mem_wdata}); end
    total++; if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin bad++; $display("FAIL rstmid_rsp got=%b exp=100", {req_ready, rsp_valid, rsp_err}); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    for (int c = 0; c < 3; c++) begin
      total++; if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL rstmid_quiet%0d got=%b exp=01", c, {rsp_valid, req_ready}); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_store();
    test_misaligned();
    test_delayed_gnt();
    test_timeout();
    test_stray_inputs();
    test_reset_mid();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
